rf_alu_sequencer: RTL and testbench
===================================

# rf_alu_sequencer

Command-driven sequencer that sits directly in front of the 8×8-bit register file (RF): accepts one ALU command at a time over a valid/ready handshake, reads up to two operands through the RF's single combinational read port on consecutive cycles, computes an 8-bit result, and writes it back through the RF write port. It is the RF's only master, driving `rd_sel`, `wr_sel`, `wr_en` and `data_in`, and consuming `data_out`.

## Interface
- `DATA_W`, 8, datapath width (matches RF)
- `SEL_W`, 4, RF select width; only 8 registers exist, so select MSB is always 0
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_op`  in  3  opcode (see Operation)
- `cmd_dst`, `cmd_src_a`, `cmd_src_b`  in  3 each  register indices 0–7
- `cmd_imm`  in  8  immediate for LDI
- `rf_rd_sel`  out  4  to RF `rd_sel`
- `rf_rd_data`  in  8  from RF `data_out` (combinational)
- `rf_wr_sel`  out  4  to RF `wr_sel`
- `rf_wr_en`  out  1  to RF `wr_en`
- `rf_wr_data`  out  8  to RF `data_in`
- `res_valid`  out  1  one-cycle completion pulse
- `res_data`  out  8  result, held until next completion
- `res_zero`, `res_carry`  out  1 each  flags, held until next completion

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 LDI (dst←imm), 6 MOV (dst←A), 7 CMP (A−B, flags only, no write).
- FSM states: IDLE, RD_A, RD_B, WB.
- IDLE: `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch all command fields. Next state: LDI→WB, MOV→RD_A, all others→RD_A.
- RD_A: `rf_rd_sel`={0,src_a}; capture `rf_rd_data` into opA at the cycle's end. Next: MOV→WB, else→RD_B.
- RD_B: `rf_rd_sel`={0,src_b}; capture opB. Next: WB.
- WB: `rf_wr_en`=1 (0 for CMP), `rf_wr_sel`={0,dst}, `rf_wr_data`=result; `res_valid`=1; `res_data`/flags registered at this edge. Next: IDLE.
- `rf_rd_sel`=0 outside RD_A/RD_B; `rf_wr_en`=0 outside WB; `rf_wr_sel`/`rf_wr_data`=0 outside WB.
- Arithmetic: 9-bit internal sum. ADD carry = bit 8. SUB/CMP carry = borrow (1 iff A<B unsigned); result wraps mod 256. Logic, LDI, MOV: carry=0. zero = (8-bit result == 0) for all ops, including CMP.
- src_a==src_b is legal (same register read twice). dst may equal a source; write happens after both reads.
- Reset (any state): next state IDLE, abort in-flight command, no RF write, all outputs 0. The RF clears its own contents on reset; the sequencer issues no writes during or on the reset cycle.

## Timing
- Accept at edge T (command latched). Write/`res_valid` cycle: T+3 (two-operand ops, CMP), T+2 (MOV), T+1 (LDI). RF write commits at the end of that cycle.
- `cmd_ready` high only in IDLE; low in the reset cycle; one-command throughput per 4/3/2 cycles. No command accepted in WB.
- Read-after-write: the next command's RD_A occurs at or after the edge that commits the previous write, so it always observes the new value; no forwarding is needed.
- `res_valid` is exactly one cycle wide; `res_data`/flags change only on completion or reset.
- Command inputs are ignored when `cmd_ready`=0.

## Structure
- Package `rf_seq_pkg`: opcode constants, FSM state encoding, `DATA_W`/`SEL_W`/register-count constants.
- Sub-module `rf_seq_alu`: combinational {op, opA, opB, imm} → {result, zero, carry}. Top holds the FSM, operand/command registers, and output registers.

## Test plan
- Reset then LDI r3←0xA5 -> `rf_wr_en` pulse at T+1, wr_sel=3, wr_data=0xA5, `res_valid`=1, zero=0.
- r1=0xF0, r2=0x20, ADD r4←r1+r2 -> rd_sel 1 then 2, write 0x10 to r4 at T+3, carry=1, zero=0.
- r1=0x05, r2=0x05, CMP r1,r2 -> `rf_wr_en` stays 0, `res_valid` at T+3, res_data=0x00, zero=1, carry=0; with r2=0x06: res_data=0xFF, carry=1.
- Back-to-back LDI r0←0x11 then MOV r5←r0 with `cmd_valid` held -> second accept on the cycle after WB; r5 written with 0x11.
- SUB r2←r2−r2 with r2=0x7E -> reads r2 twice, writes 0x00 to r2, zero=1.
- Assert `reset` during RD_B of an ADD -> no write ever occurs, outputs 0 next cycle, `cmd_ready`=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared constants and types for the register-file ALU sequencer.
// Holds datapath widths, opcode values, FSM state encoding and the
// latched command record used by rf_alu_sequencer and rf_seq_alu.
package rf_seq_pkg;

    localparam int DATA_W   = 8;   // datapath width, matches the RF
    localparam int SEL_W    = 4;   // RF select width (MSB always 0)
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;   // register index width, log2(NUM_REGS)
    localparam int OP_W     = 3;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_LDI = 3'd5;
    localparam logic [OP_W-1:0] OP_MOV = 3'd6;
    localparam logic [OP_W-1:0] OP_CMP = 3'd7;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD_A = 2'd1;
    localparam logic [1:0] ST_RD_B = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    // Command fields captured at accept and held until write-back.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [IDX_W-1:0]  dst;
        logic [IDX_W-1:0]  src_a;
        logic [IDX_W-1:0]  src_b;
        logic [DATA_W-1:0] imm;
    } cmd_t;

    // Widen a 3-bit register index to the RF select width.
    function automatic logic [SEL_W-1:0] rf_sel(input logic [IDX_W-1:0] idx);
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Purpose: combinational ALU for the RF sequencer: {op, op_a, op_b, imm} -> {result, zero, carry}.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the sequencer samples the outputs only in its write-back state.
//
// Ports:
//   op            opcode (rf_seq_pkg OP_*)
//   op_a, op_b    operands read from the RF
//   imm           immediate used by LDI
//   result        8-bit result (mod 256)
//   zero          result == 0, for every opcode including CMP
//   carry         ADD carry-out, SUB/CMP borrow (A < B unsigned), else 0
module rf_seq_alu
    import rf_seq_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum9;
    logic [DATA_W:0] diff9;

    // Zero-extended 9-bit arithmetic: bit 8 of the sum is the carry-out,
    // bit 8 of the difference is set exactly when op_a < op_b (borrow).
    assign sum9  = {1'b0, op_a} + {1'b0, op_b};
    assign diff9 = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum9[DATA_W-1:0];
                carry  = sum9[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                result = diff9[DATA_W-1:0];
                carry  = diff9[DATA_W];
            end
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_LDI:  result = imm;
            OP_MOV:  result = op_a;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rf_alu_sequencer.sv
// Purpose: single-command ALU sequencer driving the 8x8 register file's read and write ports.
// Latency: accept->write-back 1 cycle (LDI), 2 (MOV), 3 (ADD/SUB/AND/OR/XOR/CMP).
// Backpressure: cmd_ready high only in IDLE; one command in flight, no accept during WB.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_dst, cmd_src_a,
//   cmd_src_b, cmd_imm            command fields, latched at accept
//   rf_rd_sel / rf_rd_data        RF read port (data is combinational from the RF)
//   rf_wr_sel, rf_wr_en,
//   rf_wr_data                    RF write port, active in WB only
//   res_valid                     one-cycle completion pulse (the WB cycle)
//   res_data, res_zero, res_carry result and flags, held until next completion
module rf_alu_sequencer
    import rf_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [IDX_W-1:0]  cmd_src_a,
    input  logic [IDX_W-1:0]  cmd_src_b,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [SEL_W-1:0]  rf_rd_sel,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [SEL_W-1:0]  rf_wr_sel,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_carry
);

    logic [1:0]        state;
    cmd_t              cmd_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] res_data_q;
    logic              res_zero_q;
    logic              res_carry_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic              in_wb;

    rf_seq_alu u_alu (
        .op     (cmd_q.op),
        .op_a   (op_a_q),
        .op_b   (op_b_q),
        .imm    (cmd_q.imm),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_carry_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.op    <= cmd_op;
                        cmd_q.dst   <= cmd_dst;
                        cmd_q.src_a <= cmd_src_a;
                        cmd_q.src_b <= cmd_src_b;
                        cmd_q.imm   <= cmd_imm;
                        // LDI needs no operands and goes straight to write-back.
                        state       <= (cmd_op == OP_LDI) ? ST_WB : ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    op_a_q <= rf_rd_data;
                    state  <= (cmd_q.op == OP_MOV) ? ST_WB : ST_RD_B;
                end
                ST_RD_B: begin
                    op_b_q <= rf_rd_data;
                    state  <= ST_WB;
                end
                ST_WB: begin
                    res_data_q  <= alu_result;
                    res_zero_q  <= alu_zero;
                    res_carry_q <= alu_carry;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and gated by reset so that the reset
    // cycle itself issues no write and presents all-zero outputs, whatever
    // state the FSM happened to be in.
    assign in_wb     = !reset && (state == ST_WB);
    assign cmd_ready = !reset && (state == ST_IDLE);

    always_comb begin
        rf_rd_sel = '0;
        if (!reset) begin
            if (state == ST_RD_A)
                rf_rd_sel = rf_sel(cmd_q.src_a);
            else if (state == ST_RD_B)
                rf_rd_sel = rf_sel(cmd_q.src_b);
        end
    end

    assign rf_wr_en   = in_wb && (cmd_q.op != OP_CMP);
    assign rf_wr_sel  = in_wb ? rf_sel(cmd_q.dst) : '0;
    assign rf_wr_data = in_wb ? alu_result : '0;

    // The result is presented live during the completion cycle and then
    // held from the registered copy, so it is valid alongside res_valid.
    assign res_valid = in_wb;
    assign res_data  = reset ? '0   : (in_wb ? alu_result : res_data_q);
    assign res_zero  = reset ? 1'b0 : (in_wb ? alu_zero   : res_zero_q);
    assign res_carry = reset ? 1'b0 : (in_wb ? alu_carry  : res_carry_q);

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Directed bench for rf_alu_sequencer with a behavioural 8x8 register file
// attached to its RF ports. Expected values are hand-computed per vector.
module tb_rf_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op, cmd_dst, cmd_src_a, cmd_src_b;
    logic [7:0] cmd_imm;
    logic [3:0] rf_rd_sel, rf_wr_sel;
    logic [7:0] rf_rd_data, rf_wr_data;
    logic       rf_wr_en;
    logic       res_valid, res_zero, res_carry;
    logic [7:0] res_data;

    always #5 clk = ~clk;

    rf_alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dst    (cmd_dst),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_imm    (cmd_imm),
        .rf_rd_sel  (rf_rd_sel),
        .rf_rd_data (rf_rd_data),
        .rf_wr_sel  (rf_wr_sel),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_data (rf_wr_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_carry  (res_carry)
    );

    // Behavioural register file: clears on reset, combinational read.
    logic [7:0] rf [8];
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (rf_wr_en) begin
            rf[rf_wr_sel[2:0]] <= rf_wr_data;
        end
        if (rf_wr_en) wr_cnt++;
    end

    assign rf_rd_data = rf[rf_rd_sel[2:0]];

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR = 3'd3,
                           XOR = 3'd4, LDI = 3'd5, MOV = 3'd6, CMP = 3'd7;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Captured at the completion cycle of the last issued command.
    int         lat;
    logic [3:0] rds [8];
    logic       g_wr_en, g_zero, g_carry;
    logic [3:0] g_wr_sel;
    logic [7:0] g_wr_data, g_res;

    // Issue one command from an IDLE negedge, then watch up to 6 cycles for
    // completion. Returns at the negedge following the completion cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] a, input logic [2:0] b, input logic [7:0] imm);
        lat = 0;
        for (int i = 0; i < 8; i++) rds[i] = 4'hF;
        check("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
        cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            rds[n] = rf_rd_sel;
            if (res_valid) begin
                lat       = n;
                g_wr_en   = rf_wr_en;
                g_wr_sel  = rf_wr_sel;
                g_wr_data = rf_wr_data;
                g_res     = res_data;
                g_zero    = res_zero;
                g_carry   = res_carry;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("pulse_width", res_valid, 0);
        check("res_hold", res_data, g_res);
    endtask

    // Compare the captured completion against hand-computed values.
    task automatic expect_done(input string tag, input int e_lat, input logic e_wen,
                               input logic [3:0] e_sel, input logic [7:0] e_res,
                               input logic e_zero, input logic e_carry);
        check({tag, ".lat"},   lat, e_lat);
        check({tag, ".wr_en"}, g_wr_en, e_wen);
        if (e_wen) begin
            check({tag, ".wr_sel"},  g_wr_sel, e_sel);
            check({tag, ".wr_data"}, g_wr_data, e_res);
        end
        check({tag, ".res"},   g_res, e_res);
        check({tag, ".zero"},  g_zero, e_zero);
        check({tag, ".carry"}, g_carry, e_carry);
    endtask

    int snap;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm = '0;
        repeat (2) @(negedge clk);
        check("rst.ready", cmd_ready, 0);
        check("rst.wr_en", rf_wr_en, 0);
        check("rst.valid", res_valid, 0);
        check("rst.res",   res_data, 0);
        check("rst.rdsel", rf_rd_sel, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst.ready", cmd_ready, 1);

        // LDI r3 <- A5
        issue(LDI, 3'd3, 3'd0, 3'd0, 8'hA5);
        expect_done("ldi", 1, 1, 4'd3, 8'hA5, 0, 0);
        check("ldi.rf3", rf[3], 8'hA5);

        // ADD r4 <- F0 + 20 = 0x110
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'hF0);
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h20);
        issue(ADD, 3'd4, 3'd1, 3'd2, 8'h00);
        expect_done("add", 3, 1, 4'd4, 8'h10, 0, 1);
        check("add.rd1", rds[1], 4'd1);
        check("add.rd2", rds[2], 4'd2);
        check("add.rd3", rds[3], 4'd0);
        check("add.rf4", rf[4], 8'h10);

        // CMP equal and CMP less-than: flags only, no writes
        issue(LDI, 3'd1, 3'd0, 3'd0, 8'h05);
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h05);
        snap = wr_cnt;
        issue(CMP, 3'd6, 3'd1, 3'd2, 8'h00);
        expect_done("cmp_eq", 3, 0, 4'd0, 8'h00, 1, 0);
        check("cmp_eq.nowr", wr_cnt, snap);
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h06);
        snap = wr_cnt;
        issue(CMP, 3'd6, 3'd1, 3'd2, 8'h00);
        expect_done("cmp_lt", 3, 0, 4'd0, 8'hFF, 0, 1);
        check("cmp_lt.nowr", wr_cnt, snap);
        check("cmp.rf6", rf[6], 8'h00);

        // Back-to-back LDI r0 <- 11 then MOV r5 <- r0 with cmd_valid held
        cmd_valid = 1'b1; cmd_op = LDI; cmd_dst = 3'd0; cmd_imm = 8'h11;
        cmd_src_a = 3'd0; cmd_src_b = 3'd0;
        @(posedge clk);
        @(negedge clk);
        check("b2b.ldi_valid", res_valid, 1);
        check("b2b.ldi_data",  rf_wr_data, 8'h11);
        check("b2b.wb_ready",  cmd_ready, 0);
        cmd_op = MOV; cmd_dst = 3'd5; cmd_src_a = 3'd0; cmd_imm = 8'h00;
        @(negedge clk);
        check("b2b.idle_ready", cmd_ready, 1);
        check("b2b.idle_valid", res_valid, 0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b.rd_a_valid", res_valid, 0);
        check("b2b.rd_a_ready", cmd_ready, 0);
        @(negedge clk);
        check("b2b.mov_valid", res_valid, 1);
        check("b2b.mov_wen",   rf_wr_en, 1);
        check("b2b.mov_sel",   rf_wr_sel, 4'd5);
        check("b2b.mov_data",  rf_wr_data, 8'h11);
        @(negedge clk);
        check("b2b.rf5", rf[5], 8'h11);

        // SUB r2 <- r2 - r2 with r2 = 7E
        issue(LDI, 3'd2, 3'd0, 3'd0, 8'h7E);
        issue(SUB, 3'd2, 3'd2, 3'd2, 8'h00);
        expect_done("sub_same", 3, 1, 4'd2, 8'h00, 1, 0);
        check("sub.rd1", rds[1], 4'd2);
        check("sub.rd2", rds[2], 4'd2);
        check("sub.rf2", rf[2], 8'h00);

        // Logic ops on r1 = 05, r3 = A5
        issue(AND, 3'd7, 3'd1, 3'd3, 8'h00);
        expect_done("and", 3, 1, 4'd7, 8'h05, 0, 0);
        issue(OR,  3'd7, 3'd1, 3'd3, 8'h00);
        expect_done("or",  3, 1, 4'd7, 8'hA5, 0, 0);
        issue(XOR, 3'd7, 3'd1, 3'd3, 8'h00);
        expect_done("xor", 3, 1, 4'd7, 8'hA0, 0, 0);
        issue(MOV, 3'd6, 3'd3, 3'd0, 8'h00);
        expect_done("mov", 2, 1, 4'd6, 8'hA5, 0, 0);

        // Reset during RD_B of an ADD: command aborted, no write
        snap = wr_cnt;
        cmd_valid = 1'b1; cmd_op = ADD; cmd_dst = 3'd4; cmd_src_a = 3'd1; cmd_src_b = 3'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort.rd_a", rf_rd_sel, 4'd1);
        @(negedge clk);
        check("abort.rd_b", rf_rd_sel, 4'd3);
        reset = 1'b1;
        #1;
        check("abort.rst_ready", cmd_ready, 0);
        check("abort.rst_wen",   rf_wr_en, 0);
        check("abort.rst_res",   res_data, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort.rdsel", rf_rd_sel, 0);
        check("abort.valid", res_valid, 0);
        check("abort.res",   res_data, 0);
        check("abort.zero",  res_zero, 0);
        check("abort.carry", res_carry, 0);
        check("abort.ready", cmd_ready, 1);
        repeat (5) @(negedge clk);
        check("abort.nowr",  wr_cnt, snap);
        check("abort.valid2", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
